// File: rtl/riscv_clint.sv
// Core-local interruptor: msip / mtimecmp / mtime behind a single-outstanding
// request/response bus, with a prescaled free-running mtime and registered
// timer/software interrupt outputs.
//
// Bus FSM states:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | req_ready high, waiting for a request
//   S_RESP | response held on resp_* until resp_ready; no new request taken
module riscv_clint #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int TICK_DIV   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    timer_irq,
    output logic                    soft_irq
);

    localparam int          NBYTES       = DATA_WIDTH / 8;
    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  accept;
    logic [15:0]           offset;
    logic                  hit_msip, hit_mtimecmp, hit_mtime, hit_any;
    logic                  wr_msip, wr_mtimecmp, wr_mtime;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] mtime, mtimecmp;
    logic                  msip;
    logic [15:0]           prescaler;
    logic                  tick;
    logic                  unused_addr;

    // Only the low 16 address bits select a register; the rest are don't-care.
    assign offset      = req_addr[15:0];
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:16];

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [NBYTES-1:0]     mask
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_val;
        for (int b = 0; b < NBYTES; b++) begin
            if (mask[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

    // Address decode, write strobes and read mux (values before this edge's update).
    always_comb begin
        hit_msip     = (offset == OFF_MSIP);
        hit_mtimecmp = (offset == OFF_MTIMECMP);
        hit_mtime    = (offset == OFF_MTIME);
        hit_any      = hit_msip | hit_mtimecmp | hit_mtime;
        accept       = req_valid & req_ready;
        wr_msip      = accept & req_wen & hit_msip & req_wmask[0];
        wr_mtimecmp  = accept & req_wen & hit_mtimecmp;
        wr_mtime     = accept & req_wen & hit_mtime;
        rd_val       = '0;
        if (hit_msip)     rd_val = {{(DATA_WIDTH-1){1'b0}}, msip};
        if (hit_mtimecmp) rd_val = mtimecmp;
        if (hit_mtime)    rd_val = mtime;
    end

    // Bus FSM next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Response capture at acceptance; held unchanged while the response waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_err   <= ~hit_any;
            resp_rdata <= (!req_wen && hit_any) ? rd_val : '0;
        end
    end

    assign tick = (prescaler == TICK_LAST);

    // Prescaler runs untouched by software writes to mtime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    prescaler <= '0;
        else if (tick) prescaler <= '0;
        else           prescaler <= prescaler + 16'd1;
    end

    // mtime: a software write wins over the tick in the same cycle; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mtime <= '0;
        else if (wr_mtime) mtime <= merge_bytes(mtime, req_wdata, req_wmask);
        else if (tick)     mtime <= mtime + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end

    // mtimecmp and msip registers; resets leave the timer interrupt disarmed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr_mtimecmp) mtimecmp <= merge_bytes(mtimecmp, req_wdata, req_wmask);
            if (wr_msip)     msip     <= req_wdata[0];
        end
    end

    // Registered timer compare; level-sensitive, follows the compare one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_irq <= 1'b0;
        else        timer_irq <= (mtime >= mtimecmp);
    end

    assign soft_irq = msip;

endmodule

// File: tb/tb_riscv_clint.sv
// Directed self-checking bench for riscv_clint with TICK_DIV = 1.
module tb_riscv_clint;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wen = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [7:0]    req_wmask = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          timer_irq;
    logic          soft_irq;

    int nvec = 0;
    int nmis = 0;

    // Edges since reset release; equals mtime while software has not written it.
    logic [63:0] cyc;

    always #5 clk = ~clk;

    riscv_clint #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TICK_DIV(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .timer_irq  (timer_irq),
        .soft_irq   (soft_irq)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept on the next edge, then release the response.
    task automatic xfer(input logic wen, input logic [15:0] off, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] rd, output logic er,
                        output logic [63:0] acc);
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = {16'h0000, off};
        req_wdata = wd;
        req_wmask = wm;
        acc       = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("resp_valid_after_accept", 64'(resp_valid), 64'd1);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err",   64'(resp_err), 64'd0);
        check("rst_timer_irq",  64'(timer_irq), 64'd0);
        check("rst_soft_irq",   64'(soft_irq), 64'd0);
        check("rst_req_ready",  64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // mtime counts edges since release
        xfer(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er, acc);
        check("mtime_read", rd, acc);
        check("mtime_read_err", 64'(er), 64'd0);

        // Arm the timer and read it back
        xfer(1'b1, 16'h4000, 64'h20, 8'hFF, rd, er, acc);
        check("wr_cmp_rdata_zero", rd, 64'd0);
        check("wr_cmp_err", 64'(er), 64'd0);
        xfer(1'b0, 16'h4000, 64'd0, 8'h00, rd, er, acc);
        check("cmp_readback", rd, 64'h20);

        // timer_irq rises one cycle after mtime reaches 0x20
        for (int i = 0; i < 100 && cyc != 64'h20; i++) @(negedge clk);
        check("reach_mtime_20", cyc, 64'h20);
        check("irq_low_at_20", 64'(timer_irq), 64'd0);
        @(negedge clk);
        check("irq_high_after_20", 64'(timer_irq), 64'd1);

        // Disarm: timer_irq falls one cycle after the new mtimecmp takes effect
        xfer(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, acc);
        check("irq_cleared", 64'(timer_irq), 64'd0);

        // msip: only bit 0 via byte lane 0
        xfer(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, acc);
        check("soft_irq_set", 64'(soft_irq), 64'd1);
        xfer(1'b0, 16'h0000, 64'd0, 8'h00, rd, er, acc);
        check("msip_read_one", rd, 64'h1);
        xfer(1'b1, 16'h0000, 64'd0, 8'hFE, rd, er, acc);
        check("msip_lane0_masked", 64'(soft_irq), 64'd1);
        xfer(1'b1, 16'h0000, 64'd0, 8'h01, rd, er, acc);
        check("soft_irq_clear", 64'(soft_irq), 64'd0);

        // Unmapped offset
        xfer(1'b0, 16'h1000, 64'd0, 8'h00, rd, er, acc);
        check("unmapped_rd_err", 64'(er), 64'd1);
        check("unmapped_rd_data", rd, 64'd0);
        xfer(1'b1, 16'h1000, 64'h0, 8'hFF, rd, er, acc);
        check("unmapped_wr_err", 64'(er), 64'd1);
        xfer(1'b0, 16'h4000, 64'd0, 8'h00, rd, er, acc);
        check("unmapped_cmp_kept", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        xfer(1'b0, 16'h0000, 64'd0, 8'h00, rd, er, acc);
        check("unmapped_msip_kept", rd, 64'd0);

        // mtime wrap: FE written, read accepted three edges later sees 0
        xfer(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, acc);
        @(negedge clk);
        xfer(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er, acc);
        check("mtime_wrap", rd, 64'd0);

        // Partial byte mask on mtimecmp
        xfer(1'b1, 16'h4000, 64'h1234_5678_9ABC_DEF0, 8'h0F, rd, er, acc);
        xfer(1'b0, 16'h4000, 64'd0, 8'h00, rd, er, acc);
        check("cmp_low_word_only", rd, 64'hFFFF_FFFF_9ABC_DEF0);

        // Backpressure: response held stable, no second acceptance
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h0000_4000;
        @(posedge clk);
        #1;
        req_addr = 32'h0000_BFF8;
        check("stall_resp_valid0", 64'(resp_valid), 64'd1);
        check("stall_rdata0", resp_rdata, 64'hFFFF_FFFF_9ABC_DEF0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_resp_valid", 64'(resp_valid), 64'd1);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_rdata", resp_rdata, 64'hFFFF_FFFF_9ABC_DEF0);
        end
        req_valid = 1'b0;

        // Reset while in RESP drops the response at once
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_in_resp_rdata", resp_rdata, 64'd0);
        check("rst_in_resp_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 16'h4000, 64'd0, 8'h00, rd, er, acc);
        check("post_rst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        xfer(1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er, acc);
        check("post_rst_mtime", rd, acc);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/riscv_clint.md
RISCV_CLINT -- requirements
Module: riscv_clint

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of bus data and of mtime/mtimecmp.
REQ-002 Parameter ADDR_WIDTH, default 32, width of request address.
REQ-003 Parameter TICK_DIV, default 1, clk cycles per mtime increment; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  bus request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_wen  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  byte address; only bits [15:0] are decoded.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 req_wmask  input  DATA_WIDTH/8  byte write enables.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  requester accepts response.
REQ-014 resp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 resp_err  output  1  access hit an unmapped offset.
REQ-016 timer_irq  output  1  machine timer interrupt to CSR unit (mip.MTIP).
REQ-017 soft_irq  output  1  machine software interrupt to CSR unit (mip.MSIP).

Function
REQ-018 Register map, offsets in req_addr[15:0]: 0x0000 msip, 0x4000 mtimecmp, 0xBFF8 mtime; any other offset is unmapped.
REQ-019 Bus FSM has two states, IDLE and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-020 IDLE -> RESP on req_valid && req_ready; RESP -> IDLE on resp_ready; at most one request is outstanding.
REQ-021 resp_valid asserts in the cycle after acceptance; resp_rdata and resp_err stay stable while resp_valid && !resp_ready.
REQ-022 Read data is sampled from register values at the acceptance edge, before that edge's mtime increment.
REQ-023 Writes apply per byte under req_wmask at the acceptance edge; the new value is visible from the next cycle.
REQ-024 msip: only bit 0 is writable (byte lane 0); all other bits read 0; soft_irq = registered msip bit 0.
REQ-025 Unmapped access: resp_err = 1, resp_rdata = 0, no register is modified.
REQ-026 A 16-bit prescaler counts 0..TICK_DIV-1; mtime increments by 1 in each cycle where the prescaler equals TICK_DIV-1.
REQ-027 A software write to mtime overrides the increment in the same cycle; the prescaler is not reset by the write.
REQ-028 mtime wraps from 2^DATA_WIDTH-1 to 0 with no flag.
REQ-029 timer_irq is registered: it equals (mtime >= mtimecmp, unsigned) evaluated on the previous cycle's values.
REQ-030 timer_irq is level-sensitive and clears one cycle after the comparison becomes false, for example after a mtimecmp write.
REQ-031 Requests are accepted in IDLE regardless of resp_ready; resp_ready in IDLE is ignored.

Reset
REQ-032 While rst_n = 0: FSM = IDLE, req_ready = 1 after release, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-033 While rst_n = 0: mtime = 0, prescaler = 0, msip = 0, mtimecmp = all ones, timer_irq = 0, soft_irq = 0.
REQ-034 Reset asserted mid-transaction drops the pending response; no partial write survives.

Verification
REQ-035 TICK_DIV=1, reset release, then read 0xBFF8 accepted on cycle N after release -> resp_rdata = N, resp_err = 0.
REQ-036 Write mtimecmp=0x20 (wmask 0xFF), mtime free-running from 0 -> timer_irq rises in the cycle after mtime reaches 0x20; a later write mtimecmp=0xFFFF_FFFF_FFFF_FFFF -> timer_irq falls one cycle after that write takes effect.
REQ-037 Write msip=0xFFFF_FFFF_FFFF_FFFF -> soft_irq = 1 and a msip read returns 0x1; write 0 -> soft_irq = 0.
REQ-038 Read offset 0x1000 -> resp_err = 1, resp_rdata = 0; write to 0x1000 -> no register changes.
REQ-039 Write mtime=0xFFFF_FFFF_FFFF_FFFE with TICK_DIV=1 -> read two cycles later returns 0x0 (wrap); wmask=0x0F write of 0x1234_5678_9ABC_DEF0 to mtimecmp changes only bits [31:0].
REQ-040 Hold resp_ready=0 for 5 cycles -> resp_valid stays 1, req_ready stays 0, resp_rdata is stable; assert rst_n=0 in RESP -> resp_valid = 0 immediately.
